// File: rtl/lisnoc_pkg.sv
// LISNoC shared definitions: flit type encoding and
// output arbiter state type.
package lisnoc_pkg;

    localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_LAST    = 2'b10;
    localparam logic [1:0] FLIT_SINGLE  = 2'b11;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/lisnoc_rr_select.sv
// Combinational round-robin picker: first requester at or
// after ptr, wrapping at ports-1, returned one-hot.
module lisnoc_rr_select #(
    parameter int ports = 5,
    localparam int PW = (ports > 1) ? $clog2(ports) : 1
) (
    input  logic [ports-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [ports-1:0] grant,
    output logic             valid
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;

    // scan ptr, ptr+1, ... modulo ports; first hit wins
    always_comb begin
        grant = '0;
        valid = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < ports; i++) begin
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(ports)) begin
                sum = sum - (PW+1)'(ports);
            end
            idx = sum[PW-1:0];
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lisnoc_router_output_arb.sv
// LISNoC router output arbiter: per-packet round-robin
// grant among input ports feeding one output register.
module lisnoc_router_output_arb
    import lisnoc_pkg::*;
#(
    parameter int flit_data_width = 32,
    parameter int flit_type_width = 2,
    parameter int ports = 5,
    localparam int flit_width = flit_data_width + flit_type_width
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ports*flit_width-1:0] in_flit,
    input  logic [ports-1:0]            in_request,
    output logic [ports-1:0]            in_read,
    output logic [flit_width-1:0]       out_flit,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [15:0]                 pkt_count,
    output logic                        proto_err
);

    localparam int PW = (ports > 1) ? $clog2(ports) : 1;

    arb_state_e            state_q, state_d;
    logic [PW-1:0]         owner_q, owner_d;
    logic [PW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [flit_width-1:0] out_flit_q, out_flit_d;
    logic                  out_valid_q, out_valid_d;
    logic [15:0]           pkt_count_q, pkt_count_d;
    logic                  proto_err_q, proto_err_d;

    logic                  slot_free;
    logic [ports-1:0]      rr_grant;
    logic                  rr_valid;
    logic [PW-1:0]         win_idx;
    logic [PW-1:0]         sel_idx;
    logic [flit_width-1:0] sel_flit;
    logic [1:0]            sel_type;
    logic                  rd_en;

    lisnoc_rr_select #(
        .ports (ports)
    ) u_rr_select (
        .req   (in_request),
        .ptr   (rr_ptr_q),
        .grant (rr_grant),
        .valid (rr_valid)
    );

    // encode the round-robin winner as a port index
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < ports; i++) begin
            if (rr_grant[i]) begin
                win_idx = PW'(i);
            end
        end
    end

    // pick the port to read: arbiter winner or locked owner
    always_comb begin
        slot_free = !out_valid_q || out_ready;
        sel_idx   = (state_q == ACTIVE) ? owner_q : win_idx;
        sel_flit  = '0;
        for (int i = 0; i < ports; i++) begin
            if (PW'(i) == sel_idx) begin
                sel_flit = in_flit[i*flit_width +: flit_width];
            end
        end
        sel_type = sel_flit[flit_width-1 -: 2];
        if (state_q == ACTIVE) begin
            rd_en = !rst && slot_free && in_request[sel_idx];
        end else begin
            rd_en = !rst && slot_free && rr_valid;
        end
    end

    // one-hot read acknowledge back to the chosen input
    always_comb begin
        in_read = '0;
        for (int i = 0; i < ports; i++) begin
            in_read[i] = rd_en && (PW'(i) == sel_idx);
        end
    end

    // packet FSM, output register and counters next state
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        out_flit_d  = out_flit_q;
        out_valid_d = out_valid_q;
        pkt_count_d = pkt_count_q;
        proto_err_d = proto_err_q;
        if (rd_en) begin
            out_flit_d  = sel_flit;
            out_valid_d = 1'b1;
            if (state_q == IDLE) begin
                if (win_idx == PW'(ports - 1)) begin
                    rr_ptr_d = '0;
                end else begin
                    rr_ptr_d = win_idx + 1'b1;
                end
                case (sel_type)
                    FLIT_HEADER: begin
                        state_d = ACTIVE;
                        owner_d = win_idx;
                    end
                    FLIT_SINGLE: begin
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
                    default: begin
                        proto_err_d = 1'b1;
                    end
                endcase
            end else begin
                case (sel_type)
                    FLIT_LAST: begin
                        state_d     = IDLE;
                        pkt_count_d = pkt_count_q + 16'd1;
                    end
                    FLIT_PAYLOAD: begin
                        state_d = ACTIVE;
                    end
                    default: begin
                        proto_err_d = 1'b1;
                    end
                endcase
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // state registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            out_flit_q  <= '0;
            out_valid_q <= 1'b0;
            pkt_count_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            out_flit_q  <= out_flit_d;
            out_valid_q <= out_valid_d;
            pkt_count_q <= pkt_count_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign out_flit  = out_flit_q;
    assign out_valid = out_valid_q;
    assign pkt_count = pkt_count_q;
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_lisnoc_router_output_arb.sv
// Scoreboard bench for lisnoc_router_output_arb.
// Scenario tasks push expected flits; a monitor pops them.
module tb_lisnoc_router_output_arb;
    import lisnoc_pkg::*;

    localparam int P  = 5;
    localparam int FW = 34;

    logic            clk = 1'b0;
    logic            rst;
    logic [P*FW-1:0] in_flit;
    logic [P-1:0]    in_request;
    logic [P-1:0]    in_read;
    logic [FW-1:0]   out_flit;
    logic            out_valid;
    logic            out_ready;
    logic [15:0]     pkt_count;
    logic            proto_err;

    int            n_checks = 0;
    int            n_fail   = 0;
    int            exp_pkt  = 0;
    logic [FW-1:0] sb_q[$];
    logic [FW-1:0] mon_exp;

    lisnoc_router_output_arb #(
        .flit_data_width (32),
        .flit_type_width (2),
        .ports           (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_flit    (in_flit),
        .in_request (in_request),
        .in_read    (in_read),
        .out_flit   (out_flit),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .pkt_count  (pkt_count),
        .proto_err  (proto_err)
    );

    always #5 clk = ~clk;

    function automatic logic [FW-1:0] mk(logic [1:0] t, logic [31:0] d);
        return {t, d};
    endfunction

    task automatic set_flit(int p, logic [FW-1:0] f);
        in_flit[p*FW +: FW] = f;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        in_request = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        exp_pkt = 0;
    endtask

    // pop the scoreboard on every output handshake
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got %h, want no flit", out_flit);
            end else begin
                mon_exp = sb_q.pop_front();
                if (out_flit !== mon_exp) begin
                    n_fail++;
                    $display("FAIL sb_flit: got %h, want %h", out_flit, mon_exp);
                end
            end
        end
    end

    task automatic test_reset;
        rst        = 1'b1;
        out_ready  = 1'b1;
        in_request = '1;
        for (int p = 0; p < P; p++) set_flit(p, mk(FLIT_SINGLE, 32'hA0 + p));
        #2;
        n_checks++;
        if (in_read !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_in_read: got %b, want 00000", in_read);
        end
        n_checks++;
        if (out_valid !== 1'b0 || out_flit !== 34'h0) begin
            n_fail++;
            $display("FAIL rst_out: got v=%b f=%h, want v=0 f=0", out_valid, out_flit);
        end
        n_checks++;
        if (pkt_count !== 16'd0 || proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_cnt: got pkt=%0d err=%b, want 0 0", pkt_count, proto_err);
        end
        in_request = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single;
        tick;
        set_flit(2, mk(FLIT_SINGLE, 32'h4));
        in_request = 5'b00100;
        #1;
        n_checks++;
        if (in_read !== 5'b00100) begin
            n_fail++;
            $display("FAIL single_read: got %b, want 00100", in_read);
        end
        sb_q.push_back(mk(FLIT_SINGLE, 32'h4));
        exp_pkt++;
        tick;
        in_request = '0;
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_flit !== 34'h3_0000_0004) begin
            n_fail++;
            $display("FAIL single_out: got v=%b f=%h, want v=1 f=300000004", out_valid, out_flit);
        end
        n_checks++;
        if (pkt_count !== 16'(exp_pkt)) begin
            n_fail++;
            $display("FAIL single_pkt: got %0d, want %0d", pkt_count, exp_pkt);
        end
        set_flit(3, mk(FLIT_SINGLE, 32'h33));
        in_request = 5'b01100;
        #1;
        n_checks++;
        if (in_read !== 5'b01000) begin
            n_fail++;
            $display("FAIL single_ptr3: got %b, want 01000", in_read);
        end
        sb_q.push_back(mk(FLIT_SINGLE, 32'h33));
        exp_pkt++;
        tick;
        in_request = '0;
    endtask

    task automatic test_contention;
        logic [P-1:0] req;
        logic [P-1:0] one;
        int order[3];
        order = '{0, 1, 4};
        one   = 5'b00001;
        do_reset;
        tick;
        req = 5'b10011;
        for (int p = 0; p < P; p++) set_flit(p, mk(FLIT_SINGLE, 32'hC00 + p));
        for (int k = 0; k < 3; k++) begin
            in_request = req;
            #1;
            n_checks++;
            if (in_read !== (one << order[k])) begin
                n_fail++;
                $display("FAIL cont_round%0d: got %b, want %b", k, in_read, one << order[k]);
            end
            sb_q.push_back(mk(FLIT_SINGLE, 32'hC00 + order[k]));
            exp_pkt++;
            req[order[k]] = 1'b0;
            tick;
        end
        set_flit(0, mk(FLIT_SINGLE, 32'hD00));
        set_flit(1, mk(FLIT_SINGLE, 32'hD01));
        in_request = 5'b00011;
        #1;
        n_checks++;
        if (in_read !== 5'b00001) begin
            n_fail++;
            $display("FAIL cont_wrap: got %b, want 00001", in_read);
        end
        sb_q.push_back(mk(FLIT_SINGLE, 32'hD00));
        exp_pkt++;
        tick;
        in_request = '0;
        #1;
        n_checks++;
        if (pkt_count !== 16'(exp_pkt)) begin
            n_fail++;
            $display("FAIL cont_pkt: got %0d, want %0d", pkt_count, exp_pkt);
        end
    endtask

    task automatic test_packet_lock;
        logic [FW-1:0] seq[4];
        seq[0] = mk(FLIT_HEADER,  32'h100);
        seq[1] = mk(FLIT_PAYLOAD, 32'h101);
        seq[2] = mk(FLIT_PAYLOAD, 32'h102);
        seq[3] = mk(FLIT_LAST,    32'h103);
        set_flit(3, mk(FLIT_SINGLE, 32'h333));
        for (int k = 0; k < 4; k++) begin
            set_flit(1, seq[k]);
            in_request = 5'b01010;
            #1;
            n_checks++;
            if (in_read !== 5'b00010) begin
                n_fail++;
                $display("FAIL lock_flit%0d: got %b, want 00010", k, in_read);
            end
            sb_q.push_back(seq[k]);
            tick;
        end
        exp_pkt++;
        in_request = 5'b01000;
        #1;
        n_checks++;
        if (pkt_count !== 16'(exp_pkt)) begin
            n_fail++;
            $display("FAIL lock_pkt: got %0d, want %0d", pkt_count, exp_pkt);
        end
        n_checks++;
        if (in_read !== 5'b01000) begin
            n_fail++;
            $display("FAIL lock_release: got %b, want 01000", in_read);
        end
        sb_q.push_back(mk(FLIT_SINGLE, 32'h333));
        exp_pkt++;
        tick;
        in_request = '0;
    endtask

    task automatic test_backpressure;
        logic [FW-1:0] seq[5];
        int idx;
        bit stall;
        seq[0] = mk(FLIT_HEADER,  32'h200);
        seq[1] = mk(FLIT_PAYLOAD, 32'h201);
        seq[2] = mk(FLIT_PAYLOAD, 32'h202);
        seq[3] = mk(FLIT_PAYLOAD, 32'h203);
        seq[4] = mk(FLIT_LAST,    32'h204);
        set_flit(2, mk(FLIT_SINGLE, 32'h222));
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            stall      = (c >= 2 && c < 5);
            out_ready  = !stall;
            set_flit(0, seq[idx]);
            in_request = 5'b00101;
            #1;
            n_checks++;
            if (in_read !== (stall ? 5'b00000 : 5'b00001)) begin
                n_fail++;
                $display("FAIL bp_read_c%0d: got %b, want %b", c, in_read,
                         stall ? 5'b00000 : 5'b00001);
            end
            if (stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_flit !== seq[1]) begin
                    n_fail++;
                    $display("FAIL bp_hold_c%0d: got v=%b f=%h, want v=1 f=%h",
                             c, out_valid, out_flit, seq[1]);
                end
            end else begin
                sb_q.push_back(seq[idx]);
                idx++;
            end
            tick;
        end
        exp_pkt++;
        out_ready  = 1'b1;
        in_request = 5'b00100;
        #1;
        n_checks++;
        if (in_read !== 5'b00100) begin
            n_fail++;
            $display("FAIL bp_next: got %b, want 00100", in_read);
        end
        sb_q.push_back(mk(FLIT_SINGLE, 32'h222));
        exp_pkt++;
        tick;
        in_request = '0;
        tick;
        tick;
        n_checks++;
        if (sb_q.size() != 0 || pkt_count !== 16'(exp_pkt)) begin
            n_fail++;
            $display("FAIL bp_drain: got left=%0d pkt=%0d, want 0 %0d",
                     sb_q.size(), pkt_count, exp_pkt);
        end
    endtask

    task automatic test_async_reset;
        set_flit(2, mk(FLIT_HEADER, 32'h300));
        in_request = 5'b00100;
        #1;
        n_checks++;
        if (in_read !== 5'b00100) begin
            n_fail++;
            $display("FAIL ar_hdr: got %b, want 00100", in_read);
        end
        sb_q.push_back(mk(FLIT_HEADER, 32'h300));
        tick;
        set_flit(2, mk(FLIT_PAYLOAD, 32'h301));
        #1;
        sb_q.push_back(mk(FLIT_PAYLOAD, 32'h301));
        tick;
        #1;
        rst = 1'b1;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || pkt_count !== 16'd0 || in_read !== 5'b0) begin
            n_fail++;
            $display("FAIL ar_async: got v=%b pkt=%0d rd=%b, want 0 0 00000",
                     out_valid, pkt_count, in_read);
        end
        sb_q.delete();
        exp_pkt = 0;
        @(negedge clk);
        in_request = '0;
        rst = 1'b0;
        tick;
        set_flit(4, mk(FLIT_SINGLE, 32'h444));
        in_request = 5'b10000;
        #1;
        n_checks++;
        if (in_read !== 5'b10000) begin
            n_fail++;
            $display("FAIL ar_idle_grant: got %b, want 10000", in_read);
        end
        sb_q.push_back(mk(FLIT_SINGLE, 32'h444));
        exp_pkt++;
        tick;
        in_request = '0;
        #1;
        n_checks++;
        if (out_flit !== 34'h3_0000_0444 || pkt_count !== 16'(exp_pkt)) begin
            n_fail++;
            $display("FAIL ar_after: got f=%h pkt=%0d, want 300000444 %0d",
                     out_flit, pkt_count, exp_pkt);
        end
    endtask

    task automatic test_proto_err;
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_pre: got %b, want 0", proto_err);
        end
        set_flit(1, mk(FLIT_PAYLOAD, 32'hBAD));
        in_request = 5'b00010;
        #1;
        n_checks++;
        if (in_read !== 5'b00010) begin
            n_fail++;
            $display("FAIL perr_read: got %b, want 00010", in_read);
        end
        sb_q.push_back(mk(FLIT_PAYLOAD, 32'hBAD));
        tick;
        in_request = '0;
        #1;
        n_checks++;
        if (proto_err !== 1'b1 || out_flit !== 34'h0_0000_0BAD) begin
            n_fail++;
            $display("FAIL perr_set: got err=%b f=%h, want 1 000000bad", proto_err, out_flit);
        end
        for (int k = 0; k < 2; k++) begin
            set_flit(0, mk(FLIT_SINGLE, 32'h500 + k));
            in_request = 5'b00001;
            #1;
            sb_q.push_back(mk(FLIT_SINGLE, 32'h500 + k));
            exp_pkt++;
            tick;
            n_checks++;
            if (proto_err !== 1'b1) begin
                n_fail++;
                $display("FAIL perr_sticky%0d: got %b, want 1", k, proto_err);
            end
        end
        in_request = '0;
        tick;
        n_checks++;
        if (pkt_count !== 16'(exp_pkt)) begin
            n_fail++;
            $display("FAIL perr_pkt: got %0d, want %0d", pkt_count, exp_pkt);
        end
        do_reset;
        #1;
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_fail++;
            $display("FAIL perr_clear: got %b, want 0", proto_err);
        end
    endtask

    initial begin
        in_flit    = '0;
        in_request = '0;
        out_ready  = 1'b1;
        test_reset;
        test_single;
        test_contention;
        test_packet_lock;
        test_backpressure;
        test_async_reset;
        test_proto_err;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lisnoc_router_output_arb.md
# lisnoc_router_output_arb

Output-port arbitration stage of the LISNoC router, downstream of the per-input routing stages. Each input routing stage presents a one-hot direction request with its registered flit and waits for a per-direction read acknowledge. One instance per output direction collects the matching request bit from every input port and grants one port per packet by round-robin, holding the grant from header to last flit. It forwards accepted flits through a one-entry output register to the link or output FIFO using valid/ready.

## Interface
- flit_data_width, 32, flit payload bits
- flit_type_width, 2, flit type bits (MSBs of a flit)
- ports, 5, number of input ports competing for this output
- flit_width (localparam), flit_data_width+flit_type_width
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- in_flit  in  ports*flit_width  flat bus, port p at [(p+1)*flit_width-1 : p*flit_width]
- in_request  in  ports  request bit of this direction from each input routing stage
- in_read  out  ports  one-hot acknowledge, drives that port's read bit for this direction
- out_flit  out  flit_width  registered output flit
- out_valid  out  1  out_flit holds a flit
- out_ready  in  1  downstream accepts out_flit this cycle
- pkt_count  out  16  packets forwarded, counted on LAST/SINGLE acceptance, wraps
- proto_err  out  1  sticky protocol-violation flag

## Operation
- Flit type encoding: PAYLOAD=2'b00, HEADER=2'b01, LAST=2'b10, SINGLE=2'b11.
- slot_free = !out_valid || out_ready.
- FSM states:
  - IDLE (reset state).
  - ACTIVE: locked to port `owner`.
- IDLE, slot_free and any in_request:
  - winner = first requesting port scanning rr_ptr, rr_ptr+1, … mod ports.
  - in_read[winner]=1; load in_flit[winner] into output register.
  - rr_ptr <= (winner+1) mod ports.
  - HEADER -> ACTIVE with owner=winner.
  - SINGLE -> stay IDLE, pkt_count++.
  - PAYLOAD or LAST -> forwarded, stay IDLE, proto_err set.
- ACTIVE, slot_free and in_request[owner]:
  - in_read[owner]=1; load the flit.
  - LAST -> IDLE, pkt_count++.
  - PAYLOAD -> stay ACTIVE.
  - HEADER or SINGLE -> forwarded, stay ACTIVE, proto_err set.
- ACTIVE: requests from ports other than owner are ignored; in_read stays 0 for them.
- Holding in_read:
  - in_read is combinational and at most one-hot.
  - It is never asserted when slot_free=0 or when the selected in_request=0.
- Output register:
  - Loads on any in_read.
  - Otherwise out_valid clears when out_ready=1.
  - out_flit holds its value while out_valid=1 and out_ready=0.
- Flits are forwarded unmodified. Header shifting is done upstream.
- rr_ptr width: $clog2(ports), minimum 1. Wrap from ports-1 to 0.
- pkt_count: 16-bit, wraps 0xFFFF -> 0.

## Timing
- Reset values: out_valid=0, out_flit=0, pkt_count=0, proto_err=0, state=IDLE, rr_ptr=0, owner=0.
- in_read is 0 during reset.
- Latency: a flit acknowledged in cycle N appears with out_valid=1 in cycle N+1.
- Throughput: one flit per cycle while out_ready=1 and the owner requests continuously.
- Accept and drain in the same cycle (out_valid=1, out_ready=1, new read): out_valid stays 1 and the new flit replaces the old one.
- Back-pressure: out_ready=0 with out_valid=1 blocks every in_read; the grant and rr_ptr are unchanged.
- Owner requests drop mid-packet: the block stays ACTIVE and waits with no timeout.
- Reset asserted mid-packet: everything returns to reset values immediately (asynchronously). Any partially forwarded packet is abandoned, and recovering from it is the upstream's responsibility.

## Structure
- Shared package lisnoc_pkg holds:
  - flit type constants;
  - the state enum {IDLE, ACTIVE}.
- Sub-module lisnoc_rr_select (parameter ports) is combinational: it takes req and ptr and returns a one-hot winner plus a valid bit. It is reused by other arbiters.
- The FSM, output register and counters live in the top module.

## Test plan
- Single port: port 2 sends a SINGLE flit 0x3_0000_0004 with out_ready=1.
  - in_read=5'b00100 in cycle N.
  - out_flit=0x3_0000_0004 with out_valid=1 in N+1.
  - pkt_count=1, rr_ptr=3.
- Contention, three rounds with every accepted flit a SINGLE:
  - ports 0, 1 and 4 request SINGLEs simultaneously; grants are 0, 1, 4.
  - port 0 requests again; it is granted next after the pointer wraps to 0.
- Packet lock: port 1 sends HEADER, PAYLOAD, PAYLOAD, LAST while port 3 requests throughout.
  - Port 3 is not read until the cycle after LAST is accepted.
  - pkt_count increments by exactly 1 for the packet.
- Back-pressure: out_ready=0 for 3 cycles with out_valid=1.
  - in_read=0 and out_flit is stable.
  - After out_ready=1 the flow resumes with no flit lost or duplicated, checked by scoreboard.
- Reset: async rst asserted between clock edges while ACTIVE mid-packet.
  - out_valid=0 and pkt_count=0 immediately.
  - After release, a SINGLE from port 4 is granted from IDLE.
- Protocol error: a PAYLOAD arrives in IDLE.
  - It is forwarded and proto_err=1.
  - proto_err remains 1 until reset.
